// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: byte-length descriptors plus a 64-bit word stream in,
// LocalLink frames out to the Aurora 64B66B TX user interface.
// Optional header beat per frame: define AURORA_TX_FRAME_HDR_EN.
module aurora_tx_framer #(
  parameter logic [15:0] MAX_LEN_BYTES = 16'd8192
`ifdef AURORA_TX_FRAME_HDR_EN
  ,
  parameter int unsigned SEQ_W = 16,
  parameter logic [SEQ_W-1:0] SEQ_INIT = '0
`endif
) (
  input  logic        user_clk,
  input  logic        RESET_N,
  input  logic        channel_up_i,
  input  logic [15:0] len_i,
  input  logic        len_vld_i,
  output logic        len_rdy_o,
  input  logic [0:63] data_i,
  input  logic        data_vld_i,
  output logic        data_rdy_o,
  output logic [0:63] txdata_o,
  output logic        txdata_sop_n_o,
  output logic        txdata_eop_n_o,
  output logic [0:2]  txdata_mod_o,
  output logic        tx_src_rdy_n_o,
  input  logic        tx_dst_rdy_n_i,
  output logic        len_err_o,
  output logic        abort_o
);

  localparam int unsigned CNT_W = 14;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_LAST, S_FLUSH} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mod_q;
`ifdef AURORA_TX_FRAME_HDR_EN
  logic [15:0]      len_q;
  logic [SEQ_W-1:0] seq_q;
`endif

  logic             xfer_c;
  logic             out_free_c;
  logic             len_acc_c;
  logic             data_acc_c;
  logic             len_ok_c;
  logic             last_word_c;
  logic             first_sop_c;
  logic [CNT_W-1:0] len_words_c;

  // Handshake qualifiers and descriptor decode
  assign xfer_c      = ~tx_src_rdy_n_o & ~tx_dst_rdy_n_i;
  assign out_free_c  = tx_src_rdy_n_o | ~tx_dst_rdy_n_i;
  assign len_rdy_o   = RESET_N & (state_q == S_IDLE) & channel_up_i;
  assign data_rdy_o  = RESET_N & (((state_q == S_DATA) & out_free_c & channel_up_i) |
                                  (state_q == S_FLUSH));
  assign len_acc_c   = len_vld_i & len_rdy_o;
  assign data_acc_c  = data_vld_i & data_rdy_o;
  assign len_ok_c    = (len_i != 16'd0) && (len_i <= MAX_LEN_BYTES);
  assign len_words_c = CNT_W'((17'(len_i) + 17'd7) >> 3);
  assign last_word_c = (cnt_q == (words_q - CNT_W'(1)));
`ifdef AURORA_TX_FRAME_HDR_EN
  assign first_sop_c = 1'b0;
`else
  assign first_sop_c = (cnt_q == '0);
`endif

  // Framing FSM with the single output register stage
  always_ff @(posedge user_clk) begin
    if (!RESET_N) begin
      state_q        <= S_IDLE;
      words_q        <= '0;
      cnt_q          <= '0;
      mod_q          <= '0;
      txdata_o       <= '0;
      txdata_sop_n_o <= 1'b1;
      txdata_eop_n_o <= 1'b1;
      txdata_mod_o   <= '0;
      tx_src_rdy_n_o <= 1'b1;
      len_err_o      <= 1'b0;
      abort_o        <= 1'b0;
`ifdef AURORA_TX_FRAME_HDR_EN
      len_q          <= '0;
      seq_q          <= SEQ_INIT;
`endif
    end else begin
      len_err_o <= 1'b0;
      abort_o   <= 1'b0;
      if (xfer_c) tx_src_rdy_n_o <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (len_acc_c) begin
            if (!len_ok_c) begin
              len_err_o <= 1'b1;
            end else begin
              words_q <= len_words_c;
              mod_q   <= len_i[2:0];
              cnt_q   <= '0;
`ifdef AURORA_TX_FRAME_HDR_EN
              len_q   <= len_i;
              state_q <= S_HDR;
`else
              state_q <= S_DATA;
`endif
            end
          end
        end
`ifdef AURORA_TX_FRAME_HDR_EN
        S_HDR: begin
          if (!channel_up_i) begin
            tx_src_rdy_n_o <= 1'b1;
            abort_o        <= 1'b1;
            state_q        <= S_FLUSH;
          end else if (out_free_c) begin
            txdata_o       <= {16'hA55A, 16'(seq_q), len_q, 16'h0000};
            txdata_sop_n_o <= 1'b0;
            txdata_eop_n_o <= 1'b1;
            txdata_mod_o   <= '0;
            tx_src_rdy_n_o <= 1'b0;
            state_q        <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (!channel_up_i) begin
            tx_src_rdy_n_o <= 1'b1;
            abort_o        <= 1'b1;
            state_q        <= S_FLUSH;
          end else if (data_acc_c) begin
            txdata_o       <= data_i;
            txdata_sop_n_o <= ~first_sop_c;
            txdata_eop_n_o <= ~last_word_c;
            txdata_mod_o   <= last_word_c ? mod_q : 3'd0;
            tx_src_rdy_n_o <= 1'b0;
            cnt_q          <= cnt_q + CNT_W'(1);
            if (last_word_c) state_q <= S_LAST;
          end
        end
        S_LAST: begin
          if (!channel_up_i) begin
            tx_src_rdy_n_o <= 1'b1;
            abort_o        <= 1'b1;
            state_q        <= S_IDLE;
          end else if (xfer_c) begin
            state_q <= S_IDLE;
`ifdef AURORA_TX_FRAME_HDR_EN
            seq_q   <= seq_q + SEQ_W'(1);
`endif
          end
        end
        S_FLUSH: begin
          if (data_acc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_word_c) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// tb_aurora_tx_framer: directed + randomized frames against a byte-length frame model.
// Honours AURORA_TX_FRAME_HDR_EN (header beat, sequence preset near wrap).
`timescale 1ns/1ps
module tb_aurora_tx_framer;

  localparam logic [15:0] MAXL = 16'd8192;
`ifdef AURORA_TX_FRAME_HDR_EN
  localparam int HDR = 1;
  localparam logic [15:0] SEQ0 = 16'hFFFE;
  logic [15:0] seq_m;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        sop_n;
    logic        eop_n;
    logic [2:0]  mod;
  } beat_t;

  logic        user_clk;
  logic        RESET_N;
  logic        channel_up_i;
  logic [15:0] len_i;
  logic        len_vld_i;
  logic        len_rdy_o;
  logic [0:63] data_i;
  logic        data_vld_i;
  logic        data_rdy_o;
  logic [0:63] txdata_o;
  logic        txdata_sop_n_o;
  logic        txdata_eop_n_o;
  logic [0:2]  txdata_mod_o;
  logic        tx_src_rdy_n_o;
  logic        tx_dst_rdy_n_i;
  logic        len_err_o;
  logic        abort_o;

  aurora_tx_framer #(
    .MAX_LEN_BYTES(MAXL)
`ifdef AURORA_TX_FRAME_HDR_EN
    , .SEQ_INIT(SEQ0)
`endif
  ) dut (
    .user_clk(user_clk), .RESET_N(RESET_N), .channel_up_i(channel_up_i),
    .len_i(len_i), .len_vld_i(len_vld_i), .len_rdy_o(len_rdy_o),
    .data_i(data_i), .data_vld_i(data_vld_i), .data_rdy_o(data_rdy_o),
    .txdata_o(txdata_o), .txdata_sop_n_o(txdata_sop_n_o), .txdata_eop_n_o(txdata_eop_n_o),
    .txdata_mod_o(txdata_mod_o), .tx_src_rdy_n_o(tx_src_rdy_n_o), .tx_dst_rdy_n_i(tx_dst_rdy_n_i),
    .len_err_o(len_err_o), .abort_o(abort_o)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  int          n_vec = 0, n_mis = 0;
  int          cyc_n = 0, n_acc = 0, n_len_err = 0, n_abort = 0, n_rdy = 0;
  int          first_cyc = 0, last_cyc = 0;
  bit          len_took;
  beat_t       got_q[$];
  logic [63:0] src_q[$];
  beat_t       s_out;
  logic        s_src, s_rdy, s_lrdy, s_abort, s_lerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1ns after the input update (mid-low phase), then wait for the next negedge
  task automatic tick();
    #1;
    cyc_n++;
    s_out.d     = txdata_o;
    s_out.sop_n = txdata_sop_n_o;
    s_out.eop_n = txdata_eop_n_o;
    s_out.mod   = txdata_mod_o;
    s_src   = tx_src_rdy_n_o;
    s_rdy   = data_rdy_o;
    s_lrdy  = len_rdy_o;
    s_abort = abort_o;
    s_lerr  = len_err_o;
    if (tx_src_rdy_n_o === 1'b0 && tx_dst_rdy_n_i === 1'b0) begin
      got_q.push_back(s_out);
      if (got_q.size() == 1) first_cyc = cyc_n;
      last_cyc = cyc_n;
    end
    if (data_vld_i && data_rdy_o === 1'b1) begin
      n_acc++;
      if (src_q.size() > 0) src_q.delete(0);
    end
    if (len_vld_i && len_rdy_o === 1'b1) len_took = 1'b1;
    if (len_err_o === 1'b1) n_len_err++;
    if (abort_o === 1'b1) n_abort++;
    if (data_rdy_o === 1'b1) n_rdy++;
    @(negedge user_clk);
  endtask

  // kind: 0 smooth, 1 mid-frame stall, 2 channel drop, 3 reset mid-frame, 4 random
  task automatic run_frame(input int len, input int kind);
    int          w, stall_left, evt_cyc, acc0, abort0;
    bit          desc_done, evt, done;
    beat_t       exp_q[$];
    beat_t       sn;
    logic [63:0] wd;
    w = (len + 7) / 8;
    exp_q = {};
`ifdef AURORA_TX_FRAME_HDR_EN
    exp_q.push_back('{d: {16'hA55A, seq_m, 16'(len), 16'h0000}, sop_n: 1'b0, eop_n: 1'b1, mod: 3'd0});
`endif
    for (int i = 0; i < w; i++) begin
      wd = {$urandom, $urandom};
      src_q.push_back(wd);
      exp_q.push_back('{d: wd, sop_n: !(HDR == 0 && i == 0), eop_n: (i != w - 1),
                        mod: (i == w - 1) ? 3'(len % 8) : 3'd0});
    end
    got_q = {};
    acc0 = n_acc; abort0 = n_abort; len_took = 1'b0;
    desc_done = 1'b0; evt = 1'b0; done = 1'b0; stall_left = 0; evt_cyc = 0;
    sn = '0;
    len_i = 16'(len);
    for (int c = 0; c < 6000 && !done; c++) begin
      if (kind == 1 && !evt && got_q.size() == 2) begin evt = 1'b1; stall_left = 5; end
      if ((kind == 2 || kind == 3) && !evt && (n_acc - acc0) == 2) begin
        evt = 1'b1; evt_cyc = cyc_n + 1;
        if (kind == 2) channel_up_i = 1'b0; else RESET_N = 1'b0;
      end
      if (kind == 3 && evt && cyc_n == evt_cyc) begin RESET_N = 1'b1; src_q = {}; end
      len_vld_i      = !desc_done;
      tx_dst_rdy_n_i = (kind == 4) ? ($urandom_range(3) == 0) : (stall_left > 0);
      data_vld_i     = (src_q.size() > 0) && (kind != 4 || $urandom_range(3) != 0);
      data_i         = (src_q.size() > 0) ? src_q[0] : 64'd0;
      tick();
      if (len_took) desc_done = 1'b1;
      if (stall_left > 0) begin
        if (stall_left == 5) sn = s_out;
        else begin
          chk("stall_data", s_out.d, sn.d);
          chk("stall_ctl", 64'({s_out.sop_n, s_out.eop_n, s_out.mod}), 64'({sn.sop_n, sn.eop_n, sn.mod}));
        end
        chk("stall_data_rdy", 64'(s_rdy), 64'd0);
        chk("stall_src_rdy_n", 64'(s_src), 64'd0);
        stall_left--;
      end
      if (kind == 2 && evt && cyc_n == evt_cyc + 1) begin
        chk("drop_abort", 64'(s_abort), 64'd1);
        chk("drop_src_rdy_n", 64'(s_src), 64'd1);
      end
      if (kind == 3 && evt && cyc_n == evt_cyc) begin
        chk("rst_len_rdy", 64'(s_lrdy), 64'd0);
        chk("rst_data_rdy", 64'(s_rdy), 64'd0);
      end
      if (kind == 3 && evt && cyc_n == evt_cyc + 1) begin
        chk("rst_txdata", s_out.d, 64'd0);
        chk("rst_ctl", 64'({s_out.sop_n, s_out.eop_n, s_src, s_out.mod}), 64'b1110_00);
        chk("rst_pulses", 64'({s_abort, s_lerr}), 64'd0);
        done = 1'b1;
      end
      if (kind == 0 || kind == 1 || kind == 4)
        done = desc_done && src_q.size() == 0 && got_q.size() == exp_q.size();
      if (kind == 2) done = evt && src_q.size() == 0 && cyc_n > evt_cyc;
    end
    chk($sformatf("frame_done_len%0d", len), 64'(done), 64'd1);
    if (kind == 2 || kind == 3)
      while (exp_q.size() > HDR + 2) exp_q.delete(exp_q.size() - 1);
    chk($sformatf("beat_count_len%0d", len), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("beat%0d_data", i), got_q[i].d, exp_q[i].d);
      chk($sformatf("beat%0d_sop_n", i), 64'(got_q[i].sop_n), 64'(exp_q[i].sop_n));
      chk($sformatf("beat%0d_eop_n", i), 64'(got_q[i].eop_n), 64'(exp_q[i].eop_n));
      if (!exp_q[i].eop_n) chk($sformatf("beat%0d_mod", i), 64'(got_q[i].mod), 64'(exp_q[i].mod));
    end
    if (kind == 0) chk("contiguous", 64'(last_cyc - first_cyc), 64'(exp_q.size() - 1));
    if (kind == 2) begin
      chk("abort_pulses", 64'(n_abort - abort0), 64'd1);
      chk("flushed_words", 64'(n_acc - acc0 - 2), 64'(w - 2));
      data_vld_i = 1'b0;
      tick();
      chk("post_flush_data_rdy", 64'(s_rdy), 64'd0);
      channel_up_i = 1'b1;
    end
`ifdef AURORA_TX_FRAME_HDR_EN
    if (kind == 0 || kind == 1 || kind == 4) seq_m = seq_m + 16'd1;
    if (kind == 3) seq_m = SEQ0;
`endif
    len_vld_i = 1'b0; data_vld_i = 1'b0; tx_dst_rdy_n_i = 1'b0;
  endtask

  // Rejected descriptors: one len_err pulse each, no data consumed, no beats
  task automatic len_err_test();
    int e0, a0, r0;
    e0 = n_len_err; a0 = n_acc; r0 = n_rdy;
    got_q = {};
    data_vld_i = 1'b1;
    data_i = 64'hDEAD_BEEF_0000_0001;
    for (int k = 0; k < 2; k++) begin
      len_i = (k == 0) ? 16'd0 : MAXL + 16'd1;
      len_vld_i = 1'b1; len_took = 1'b0;
      for (int c = 0; c < 20 && !len_took; c++) tick();
      chk("err_desc_taken", 64'(len_took), 64'd1);
      len_vld_i = 1'b0;
      tick(); tick(); tick();
    end
    chk("len_err_pulses", 64'(n_len_err - e0), 64'd2);
    chk("err_no_beats", 64'(got_q.size()), 64'd0);
    chk("err_no_words", 64'(n_acc - a0), 64'd0);
    chk("err_data_rdy", 64'(n_rdy - r0), 64'd0);
    data_vld_i = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; channel_up_i = 1'b1; len_i = '0; len_vld_i = 1'b0;
    data_i = '0; data_vld_i = 1'b0; tx_dst_rdy_n_i = 1'b0;
`ifdef AURORA_TX_FRAME_HDR_EN
    seq_m = SEQ0;
`endif
    @(negedge user_clk);
    tick(); tick();
    chk("reset_txdata", s_out.d, 64'd0);
    chk("reset_ctl", 64'({s_out.sop_n, s_out.eop_n, s_src, s_out.mod}), 64'b1110_00);
    chk("reset_rdy", 64'({s_lrdy, s_rdy}), 64'd0);
    chk("reset_pulses", 64'({s_abort, s_lerr}), 64'd0);
    RESET_N = 1'b1;
    tick();
    chk("idle_len_rdy", 64'(s_lrdy), 64'd1);
    chk("idle_data_rdy", 64'(s_rdy), 64'd0);

    run_frame(20, 0);
    run_frame(8, 0);
    run_frame(1, 0);
    run_frame(40, 1);
    len_err_test();
    for (int i = 0; i < 5; i++) run_frame(int'($urandom_range(200, 1)), 4);
    run_frame(int'(MAXL), 4);
    run_frame(48, 2);
    run_frame(16, 0);
    run_frame(40, 3);
    run_frame(24, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
